dbg_cap_src_mux: RTL and testbench

Parametrised debug capture source selector for the ADC capture debug path. It picks one of `NUM_SRC` packed debug buses by `capture_mode` and filters the samples with optional change-only and decimation qualifiers. Qualified samples pass through a 2-entry output buffer with a valid/ready handshake. Samples dropped on a full buffer are flagged and counted. It feeds the capture memory writer in place of the fixed 3-mode source generator.

---
 rtl/dbg_cap_src_mux.sv | 179 +++++++++++++++++
 tb/tb_dbg_cap_src_mux.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_cap_src_mux.sv
// dbg_cap_src_mux
// Debug capture source selector for the ADC capture debug path. One of
// NUM_SRC packed debug buses is picked by capture_mode. Its samples go through
// an input register stage, an optional change-only filter and a 1-in-(N+1)
// decimator, and then into a 2-entry output FIFO.
//
// Ports:
//   clk          capture clock, rising edge
//   rst          asynchronous active-high reset
//   capture_mode 0 = off, k in 1..NUM_SRC selects source k-1, others = off
//   cfg_chg_only drop samples equal to the last one that passed the change filter
//   cfg_decim    keep 1 of every cfg_decim+1 samples that pass the change filter
//   src_data     packed sources, source i at [i*DATA_W +: DATA_W]
//   src_vld      per-source sample strobe
//   cap_data     head of the output FIFO (registered)
//   cap_data_vld cap_data holds a sample (registered)
//   cap_data_rdy consumer ready
//   cap_mode_vld a valid source is selected and the block has settled
//   cap_ovf      sticky flag: a qualified sample was dropped on a full FIFO
//   cap_drop_cnt saturating count of dropped qualified samples
//
// Handshake: a sample transfers on a rising edge where cap_data_vld and
// cap_data_rdy are both 1. While cap_data_vld is 1 and cap_data_rdy is 0,
// cap_data and cap_data_vld hold their values. cap_data_vld does not depend
// combinationally on cap_data_rdy.
//
// A change of capture_mode (flush) clears the pipeline, FIFO, filter history,
// decimation phase and drop statistics. The cfg_* inputs take effect
// immediately and never cause a flush.

`timescale 1ns/1ps

module dbg_cap_src_mux #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int MODE_W  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MODE_W-1:0]         capture_mode,
  input  logic                      cfg_chg_only,
  input  logic [7:0]                cfg_decim,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_vld,
  output logic [DATA_W-1:0]         cap_data,
  output logic                      cap_data_vld,
  input  logic                      cap_data_rdy,
  output logic                      cap_mode_vld,
  output logic                      cap_ovf,
  output logic [CNT_W-1:0]          cap_drop_cnt
);

  logic [MODE_W-1:0] mode_q;
  logic              flush;
  logic              mode_ok;

  logic              sel_vld;
  logic [DATA_W-1:0] sel_data;

  logic              stg_vld;
  logic [DATA_W-1:0] stg_data;

  logic              have_last;
  logic [DATA_W-1:0] last_data;
  logic [7:0]        dec_cnt;

  // Two-entry FIFO: the head register drives the outputs directly.
  logic              head_vld;
  logic [DATA_W-1:0] head_data;
  logic              tail_vld;
  logic [DATA_W-1:0] tail_data;

  logic              chg_drop;
  logic              pass_chg;
  logic              qual;
  logic              pop;
  logic              wr;
  logic              drop;

  assign flush   = (capture_mode != mode_q);
  assign mode_ok = (mode_q != '0) && (mode_q <= MODE_W'(NUM_SRC));

  // Source select. It is keyed on the registered mode, so a mode change
  // cannot reach stage 1 before the flush has taken effect.
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_q == MODE_W'(i + 1)) begin
        sel_vld  = src_vld[i];
        sel_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Qualification of the sample held in stage 1.
  assign chg_drop = cfg_chg_only && have_last && (stg_data == last_data);
  assign pass_chg = stg_vld && !chg_drop;
  assign qual     = pass_chg && (dec_cnt == 8'd0);

  // A full FIFO still accepts a write when the head is popped on the same edge.
  assign pop  = head_vld && cap_data_rdy;
  assign wr   = qual && (!tail_vld || pop);
  assign drop = qual && tail_vld && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= '0;
      cap_mode_vld <= 1'b0;
      stg_vld      <= 1'b0;
      stg_data     <= '0;
      have_last    <= 1'b0;
      last_data    <= '0;
      dec_cnt      <= 8'd0;
      head_vld     <= 1'b0;
      head_data    <= '0;
      tail_vld     <= 1'b0;
      tail_data    <= '0;
      cap_ovf      <= 1'b0;
      cap_drop_cnt <= '0;
    end else if (flush) begin
      mode_q       <= capture_mode;
      cap_mode_vld <= 1'b0;
      stg_vld      <= 1'b0;
      have_last    <= 1'b0;
      dec_cnt      <= 8'd0;
      head_vld     <= 1'b0;
      tail_vld     <= 1'b0;
      cap_ovf      <= 1'b0;
      cap_drop_cnt <= '0;
    end else begin
      cap_mode_vld <= mode_ok;
      stg_vld      <= mode_ok && sel_vld;
      stg_data     <= sel_data;

      if (pass_chg) begin
        last_data <= stg_data;
        have_last <= 1'b1;
        dec_cnt   <= (dec_cnt == 8'd0) ? cfg_decim : dec_cnt - 8'd1;
      end

      case ({pop, wr})
        2'b11: begin
          if (tail_vld) begin
            head_data <= tail_data;
            tail_data <= stg_data;
          end else begin
            head_data <= stg_data;
          end
        end
        2'b10: begin
          if (tail_vld) head_data <= tail_data;
          head_vld <= tail_vld;
          tail_vld <= 1'b0;
        end
        2'b01: begin
          if (!head_vld) begin
            head_data <= stg_data;
            head_vld  <= 1'b1;
          end else begin
            tail_data <= stg_data;
            tail_vld  <= 1'b1;
          end
        end
        default: ;
      endcase

      if (drop) begin
        cap_ovf <= 1'b1;
        if (cap_drop_cnt != {CNT_W{1'b1}}) cap_drop_cnt <= cap_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign cap_data     = head_data;
  assign cap_data_vld = head_vld;

endmodule

// File: tb/tb_dbg_cap_src_mux.sv
`timescale 1ns/1ps

module tb_dbg_cap_src_mux;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 32;
  localparam int MODE_W  = 4;
  localparam int CNT_W   = 16;
  localparam int W       = 32;

  // ---------------- clock / reset ----------------
  logic                      clk = 1'b0;
  logic                      rst;
  logic [MODE_W-1:0]         capture_mode;
  logic                      cfg_chg_only;
  logic [7:0]                cfg_decim;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_vld;
  logic [DATA_W-1:0]         cap_data;
  logic                      cap_data_vld;
  logic                      cap_data_rdy;
  logic                      cap_mode_vld;
  logic                      cap_ovf;
  logic [CNT_W-1:0]          cap_drop_cnt;

  always #5 clk = ~clk;

  dbg_cap_src_mux #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .MODE_W(MODE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .capture_mode(capture_mode),
    .cfg_chg_only(cfg_chg_only),
    .cfg_decim(cfg_decim),
    .src_data(src_data),
    .src_vld(src_vld),
    .cap_data(cap_data),
    .cap_data_vld(cap_data_vld),
    .cap_data_rdy(cap_data_rdy),
    .cap_mode_vld(cap_mode_vld),
    .cap_ovf(cap_ovf),
    .cap_drop_cnt(cap_drop_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(name, got_q[i], exp_q[i]);
  endtask

  // ---------------- behavioural model ----------------
  // Sample-level view: one pending sample, a bounded queue of 2, and a
  // "samples still to skip" count for decimation.
  int           m_mode;
  bit           m_mode_vld;
  bit           m_pend_vld;
  logic [W-1:0] m_pend;
  bit           m_have_last;
  logic [W-1:0] m_last;
  int           m_skip;
  logic [W-1:0] m_buf[$];
  bit           m_ovf;
  int           m_drops;

  task automatic model_reset();
    m_mode = 0; m_mode_vld = 0; m_pend_vld = 0; m_pend = '0;
    m_have_last = 0; m_last = '0; m_skip = 0; m_buf.delete();
    m_ovf = 0; m_drops = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else if (int'(capture_mode) != m_mode) begin
      model_reset();
      m_mode = int'(capture_mode);
    end else begin
      bit qual;
      bit sel_ok;
      qual   = 0;
      sel_ok = (m_mode >= 1) && (m_mode <= NUM_SRC);
      if (m_pend_vld && !(cfg_chg_only && m_have_last && m_pend == m_last)) begin
        m_last = m_pend;
        m_have_last = 1;
        if (m_skip == 0) begin
          qual = 1;
          m_skip = int'(cfg_decim);
        end else begin
          m_skip--;
        end
      end
      if (m_buf.size() > 0 && cap_data_rdy) void'(m_buf.pop_front());
      if (qual) begin
        if (m_buf.size() < 2) m_buf.push_back(m_pend);
        else begin
          m_ovf = 1;
          if (m_drops < (1 << CNT_W) - 1) m_drops++;
        end
      end
      m_pend_vld = sel_ok && src_vld[sel_ok ? m_mode - 1 : 0];
      m_pend     = sel_ok ? src_data[(m_mode - 1)*DATA_W +: DATA_W] : '0;
      m_mode_vld = sel_ok;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cap_data", cap_data, 32'h0);
      chk("rst_cap_data_vld", 32'(cap_data_vld), 32'h0);
      chk("rst_cap_ovf", 32'(cap_ovf), 32'h0);
    end else begin
      chk("cap_data_vld", 32'(cap_data_vld), 32'(m_buf.size() > 0));
      if (cap_data_vld && m_buf.size() > 0) chk("cap_data", cap_data, m_buf[0]);
      chk("cap_mode_vld", 32'(cap_mode_vld), 32'(m_mode_vld));
      chk("cap_ovf", 32'(cap_ovf), 32'(m_ovf));
      chk("cap_drop_cnt", 32'(cap_drop_cnt), 32'(m_drops));
      if (cap_data_vld && cap_data_rdy) got_q.push_back(cap_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int src, input logic [W-1:0] d);
    src_data[src*DATA_W +: DATA_W] = d;
    src_vld[src] = 1'b1;
  endtask

  task automatic strobe(input int src, input logic [W-1:0] d);
    put(src, d);
    cyc();
    src_vld = '0;
  endtask

  task automatic go_mode(input int m);
    capture_mode = MODE_W'(m);
    repeat (3) cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    capture_mode = '0;
    cfg_chg_only = 1'b0;
    cfg_decim = 8'd0;
    src_data = '0;
    src_vld = '0;
    cap_data_rdy = 1'b1;
    repeat (2) cyc();
    chk("reset_data", cap_data, 32'h0);
    chk("reset_vld", 32'(cap_data_vld), 32'h0);
    chk("reset_mode_vld", 32'(cap_mode_vld), 32'h0);
    chk("reset_ovf", 32'(cap_ovf), 32'h0);
    chk("reset_drop_cnt", 32'(cap_drop_cnt), 32'h0);
    rst = 1'b0;
    cyc();

    // Mode 2, three consecutive strobes on source 1, latency 2.
    go_mode(2);
    got_q.delete();
    put(1, 32'h11); cyc();
    chk("t1_lat_vld_t1", 32'(cap_data_vld), 32'h0);
    put(1, 32'h22); cyc();
    chk("t1_lat_vld_t2", 32'(cap_data_vld), 32'h1);
    chk("t1_lat_data_t2", cap_data, 32'h11);
    put(1, 32'h33); cyc();
    chk("t1_data_t3", cap_data, 32'h22);
    src_vld = '0; cyc();
    chk("t1_data_t4", cap_data, 32'h33);
    cyc();
    chk("t1_vld_t5", 32'(cap_data_vld), 32'h0);
    chk("t1_mode_vld", 32'(cap_mode_vld), 32'h1);
    chk("t1_drop_cnt", 32'(cap_drop_cnt), 32'h0);
    exp_q.delete(); exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
    check_got("t1_stream");

    // Mode 1, change-only filter.
    go_mode(1);
    cfg_chg_only = 1'b1;
    got_q.delete();
    strobe(0, 32'd5); strobe(0, 32'd5); strobe(0, 32'd7); strobe(0, 32'd7); strobe(0, 32'd5);
    repeat (4) cyc();
    exp_q.delete(); exp_q.push_back(32'd5); exp_q.push_back(32'd7); exp_q.push_back(32'd5);
    check_got("t2_chg_only");
    chk("t2_ovf", 32'(cap_ovf), 32'h0);
    cfg_chg_only = 1'b0;

    // Out-of-range mode produces nothing; then mode 1 with decimation by 4.
    go_mode(7);
    got_q.delete();
    strobe(0, 32'hdead); strobe(1, 32'hbeef); strobe(3, 32'hf00d);
    repeat (3) cyc();
    chk("t3_bad_mode_vld", 32'(cap_mode_vld), 32'h0);
    chk("t3_bad_mode_out", 32'(got_q.size()), 32'h0);
    go_mode(1);
    cfg_decim = 8'd3;
    got_q.delete();
    for (int i = 0; i < 12; i++) strobe(0, 32'h100 + 32'(i));
    repeat (4) cyc();
    exp_q.delete(); exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    check_got("t3_decim");
    cfg_decim = 8'd0;

    // Backpressure: FIFO holds 1,2, three drops.
    go_mode(0);
    go_mode(1);
    cap_data_rdy = 1'b0;
    got_q.delete();
    for (int i = 1; i <= 5; i++) strobe(0, 32'(i));
    repeat (2) cyc();
    chk("t4_none_out", 32'(got_q.size()), 32'h0);
    chk("t4_head", cap_data, 32'h1);
    chk("t4_ovf", 32'(cap_ovf), 32'h1);
    chk("t4_drop_cnt", 32'(cap_drop_cnt), 32'h3);
    chk("t4_hold_data", cap_data, 32'h1);
    cap_data_rdy = 1'b1;
    repeat (4) cyc();
    exp_q.delete(); exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    check_got("t4_drain");

    // Mode switch 1 -> 3 during back-to-back strobes, after building overflow.
    go_mode(0);
    go_mode(1);
    cap_data_rdy = 1'b0;
    got_q.delete();
    for (int k = 0; k < 14; k++) begin
      if (k == 5) begin
        chk("t5_pre_ovf", 32'(cap_ovf), 32'h1);
        chk("t5_pre_drop_cnt", 32'(cap_drop_cnt), 32'h2);
      end
      if (k == 8) begin
        chk("t5_flush_mode_vld", 32'(cap_mode_vld), 32'h0);
        chk("t5_flush_ovf", 32'(cap_ovf), 32'h0);
        chk("t5_flush_drop_cnt", 32'(cap_drop_cnt), 32'h0);
        chk("t5_flush_vld", 32'(cap_data_vld), 32'h0);
        got_q.delete();
      end
      if (k == 9) chk("t5_settled_mode_vld", 32'(cap_mode_vld), 32'h1);
      src_data[0*DATA_W +: DATA_W] = 32'hA0 + 32'(k);
      src_data[2*DATA_W +: DATA_W] = 32'hC0 + 32'(k);
      src_vld = 4'b0101;
      if (k == 5) cap_data_rdy = 1'b1;
      if (k == 7) capture_mode = 4'd3;
      cyc();
    end
    src_vld = '0;
    repeat (4) cyc();
    exp_q.delete();
    for (int k = 8; k < 14; k++) exp_q.push_back(32'hC0 + 32'(k));
    check_got("t5_after_flush");

    // Reset with a full FIFO and overflow, then resume in mode 1.
    go_mode(1);
    cap_data_rdy = 1'b0;
    got_q.delete();
    for (int i = 1; i <= 4; i++) strobe(0, 32'h40 + 32'(i));
    repeat (2) cyc();
    chk("t6_pre_ovf", 32'(cap_ovf), 32'h1);
    chk("t6_pre_vld", 32'(cap_data_vld), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_data", cap_data, 32'h0);
    chk("t6_rst_vld", 32'(cap_data_vld), 32'h0);
    chk("t6_rst_mode_vld", 32'(cap_mode_vld), 32'h0);
    chk("t6_rst_ovf", 32'(cap_ovf), 32'h0);
    chk("t6_rst_drop_cnt", 32'(cap_drop_cnt), 32'h0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("t6_flush_mode_vld", 32'(cap_mode_vld), 32'h0);
    cyc();
    chk("t6_resume_mode_vld", 32'(cap_mode_vld), 32'h1);
    cap_data_rdy = 1'b1;
    got_q.delete();
    strobe(0, 32'h55); strobe(0, 32'h66);
    repeat (4) cyc();
    exp_q.delete(); exp_q.push_back(32'h55); exp_q.push_back(32'h66);
    check_got("t6_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- run bound ----------------
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: run did not complete, time %0t limit 200000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
